// File: rtl/pool2x2_reader.sv
// pool2x2_reader
// Reads a complete FMAP_W x FMAP_W x FMAP_CH feature map back from the feature
// BRAM and performs 2x2 stride-2 max pooling per channel. The pooled map is
// emitted as a (pool_addr, pool_dout, pool_valid) stream for the next layer.
//
// Ports:
//   iclk        clock, rising edge
//   irst        asynchronous active-low reset
//   start       frame-ready pulse, honoured only in IDLE
//   rd_en       BRAM read enable
//   rd_addr     BRAM read address (ch*W*W + row*W + col)
//   rd_data     BRAM read data, signed, valid one cycle after rd_en
//   pool_valid  one-cycle strobe, pooled word present
//   pool_addr   pooled word index (ch*(W/2)^2 + pr*(W/2) + pc)
//   pool_dout   pooled word, signed
//   busy        high from start accept until done
//   done        one-cycle pulse after the last pooled word
//
// Build option: define POOL_RELU_EN to clamp negative pooled words to zero on
// the output register. Timing is identical with or without it.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start
// S_READ  | issuing one BRAM read per cycle
// S_DRAIN | reads finished, waiting for the last window
// S_DONE  | done pulse, back to idle next cycle

module pool2x2_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int FMAP_W     = 28,
  parameter int FMAP_CH    = 2
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  start,
  output logic                  rd_en,
  output logic [10:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pool_valid,
  output logic [8:0]            pool_addr,
  output logic [DATA_WIDTH-1:0] pool_dout,
  output logic                  busy,
  output logic                  done
);

  localparam int HALF = FMAP_W / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = (FMAP_CH > 1) ? $clog2(FMAP_CH) : 1;
  localparam logic [PW-1:0] P_LAST    = PW'(HALF - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(FMAP_CH - 1);
  localparam logic [8:0]    WIN_LAST  = 9'(HALF * HALF * FMAP_CH - 1);
  localparam logic [10:0]   ROW_STEP  = 11'(FMAP_W);
  localparam logic [10:0]   PAIR_STEP = 11'(2 * FMAP_W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_n;

  logic [1:0]    sub_q, sub_n;
  logic [PW-1:0] pc_q, pc_n, pr_q, pr_n;
  logic [CW-1:0] ch_q, ch_n;
  logic [10:0]   row_base_q, row_base_n;
  logic [10:0]   addr_n;
  logic          last_rd;

  logic                         rd_en_d, busy_d, done_d;
  logic                         dv_q;
  logic [1:0]                   dsub_q;
  logic signed [DATA_WIDTH-1:0] max_q, cand, pool_next;
  logic [8:0]                   out_idx_q;

  assign last_rd = (sub_q == 2'd3) && (pc_q == P_LAST) && (pr_q == P_LAST) && (ch_q == C_LAST);

  // row_base tracks ch*W*W + 2*pr*W. Stepping by 2W on every pc wrap also
  // lands exactly on the next channel base after the last window row.
  always_comb begin
    sub_n      = sub_q + 2'd1;
    pc_n       = pc_q;
    pr_n       = pr_q;
    ch_n       = ch_q;
    row_base_n = row_base_q;
    if (sub_q == 2'd3) begin
      if (pc_q == P_LAST) begin
        pc_n       = '0;
        row_base_n = row_base_q + PAIR_STEP;
        if (pr_q == P_LAST) begin
          pr_n = '0;
          ch_n = ch_q + CW'(1);
        end else begin
          pr_n = pr_q + PW'(1);
        end
      end else begin
        pc_n = pc_q + PW'(1);
      end
    end
    addr_n = row_base_n + (sub_n[1] ? ROW_STEP : 11'd0) + 11'({pc_n, 1'b0}) + 11'(sub_n[0]);
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start) state_n = S_READ;
      S_READ:  if (last_rd) state_n = S_DRAIN;
      // the only strobe seen while draining is the final window
      S_DRAIN: if (pool_valid && (pool_addr == WIN_LAST)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // decoded from the next state so the registered outputs line up with it
  always_comb begin
    rd_en_d = (state_n == S_READ);
    busy_d  = (state_n == S_READ) || (state_n == S_DRAIN);
    done_d  = (state_n == S_DONE);
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_addr    <= '0;
      sub_q      <= '0;
      pc_q       <= '0;
      pr_q       <= '0;
      ch_q       <= '0;
      row_base_q <= '0;
    end else begin
      rd_en <= rd_en_d;
      busy  <= busy_d;
      done  <= done_d;
      if (state_q == S_IDLE && start) begin
        rd_addr    <= '0;
        sub_q      <= '0;
        pc_q       <= '0;
        pr_q       <= '0;
        ch_q       <= '0;
        row_base_q <= '0;
      end else if (state_q == S_READ && !last_rd) begin
        rd_addr    <= addr_n;
        sub_q      <= sub_n;
        pc_q       <= pc_n;
        pr_q       <= pr_n;
        ch_q       <= ch_n;
        row_base_q <= row_base_n;
      end
    end
  end

  // dv/dsub follow each read by one cycle so they line up with rd_data
  always_comb begin
    if (dsub_q == 2'd0)                  cand = $signed(rd_data);
    else if ($signed(rd_data) > max_q)   cand = $signed(rd_data);
    else                                 cand = max_q;
  end

`ifdef POOL_RELU_EN
  assign pool_next = cand[DATA_WIDTH-1] ? '0 : cand;
`else
  assign pool_next = cand;
`endif

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      dv_q       <= 1'b0;
      dsub_q     <= '0;
      max_q      <= '0;
      pool_valid <= 1'b0;
      pool_addr  <= '0;
      pool_dout  <= '0;
      out_idx_q  <= '0;
    end else begin
      dv_q       <= rd_en;
      dsub_q     <= sub_q;
      pool_valid <= dv_q && (dsub_q == 2'd3);
      if (dv_q) max_q <= cand;
      if (state_q == S_IDLE && start) begin
        out_idx_q <= '0;
      end else if (dv_q && dsub_q == 2'd3) begin
        pool_dout <= pool_next;
        pool_addr <= out_idx_q;
        out_idx_q <= out_idx_q + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_reader.sv
module tb_pool2x2_reader;

  logic        iclk = 1'b0;
  logic        irst;
  logic        start;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic        pool_valid;
  logic [8:0]  pool_addr;
  logic [15:0] pool_dout;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:2047];

  int n_chk = 0;
  int n_pass = 0;

  int f_str, f_first, f_last, f_done_n, f_done_cyc;
  int f_bad_data, f_bad_addr, f_bad_time, f_consec, f_busy_bad, f_ren_bad;
  int f_ra [4];
  int f_out [392];

  pool2x2_reader #(.DATA_WIDTH(16), .FMAP_W(28), .FMAP_CH(2)) dut (
    .iclk(iclk), .irst(irst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_valid(pool_valid), .pool_addr(pool_addr), .pool_dout(pool_dout),
    .busy(busy), .done(done)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int cell_addr(input int idx, input int s);
    int ch, r, pr, pc;
    ch = idx / 196;
    r  = idx % 196;
    pr = r / 14;
    pc = r % 14;
    return ch * 784 + (2 * pr + s / 2) * 28 + 2 * pc + s % 2;
  endfunction

  function automatic int ref_pool(input int idx);
    int m, v;
    m = int'($signed(mem[cell_addr(idx, 0)]));
    for (int s = 1; s < 4; s++) begin
      v = int'($signed(mem[cell_addr(idx, s)]));
      if (v > m) m = v;
    end
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  // called just after a negedge; start is sampled at the next posedge (E0)
  task automatic run_frame(input int xs1, input int xs2, input int ncyc);
    bit prev_v;
    prev_v = 0;
    f_str = 0; f_first = -1; f_last = -1; f_done_n = 0; f_done_cyc = -1;
    f_bad_data = 0; f_bad_addr = 0; f_bad_time = 0; f_consec = 0;
    f_busy_bad = 0; f_ren_bad = 0;
    for (int i = 0; i < 4; i++) f_ra[i] = -1;
    start = 1'b1;
    @(negedge iclk);
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      start = (cyc == xs1) || (cyc == xs2);
      if (cyc < 4 && rd_en) f_ra[cyc] = int'(rd_addr);
      if (busy !== (cyc <= 1569)) f_busy_bad++;
      if (rd_en !== (cyc <= 1567)) f_ren_bad++;
      if (pool_valid) begin
        if (prev_v) f_consec++;
        if (int'(pool_addr) != f_str) f_bad_addr++;
        if (cyc != 4 * f_str + 5) f_bad_time++;
        if (pool_addr < 9'd392) begin
          f_out[pool_addr] = int'($signed(pool_dout));
          if (f_out[pool_addr] != ref_pool(int'(pool_addr))) f_bad_data++;
        end
        if (f_first < 0) f_first = cyc;
        f_last = cyc;
        f_str++;
      end
      prev_v = pool_valid;
      if (done) begin
        f_done_n++;
        f_done_cyc = cyc;
      end
      @(negedge iclk);
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " strobes"}, f_str, 392);
    chk({tag, " first_cyc"}, f_first, 5);
    chk({tag, " last_cyc"}, f_last, 1569);
    chk({tag, " done_count"}, f_done_n, 1);
    chk({tag, " done_cyc"}, f_done_cyc, 1570);
    chk({tag, " data_errs"}, f_bad_data, 0);
    chk({tag, " addr_errs"}, f_bad_addr, 0);
    chk({tag, " timing_errs"}, f_bad_time, 0);
    chk({tag, " back_to_back_strobes"}, f_consec, 0);
    chk({tag, " busy_errs"}, f_busy_bad, 0);
    chk({tag, " rd_en_errs"}, f_ren_bad, 0);
    chk({tag, " rd_addr0"}, f_ra[0], 0);
    chk({tag, " rd_addr1"}, f_ra[1], 1);
    chk({tag, " rd_addr2"}, f_ra[2], 28);
    chk({tag, " rd_addr3"}, f_ra[3], 29);
  endtask

  task automatic check_ramp(input string tag);
    chk({tag, " pool0"}, f_out[0], 29);
    chk({tag, " pool13"}, f_out[13], 55);
    chk({tag, " pool196"}, f_out[196], 813);
    chk({tag, " pool391"}, f_out[391], 1567);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " rd_en"}, int'(rd_en), 0);
    chk({tag, " rd_addr"}, int'(rd_addr), 0);
    chk({tag, " pool_valid"}, int'(pool_valid), 0);
    chk({tag, " pool_addr"}, int'(pool_addr), 0);
    chk({tag, " pool_dout"}, int'(pool_dout), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    irst  = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 2048; a++) mem[a] = 16'(a);
    repeat (3) @(negedge iclk);
    check_outputs_zero("reset");
    irst = 1'b1;
    @(negedge iclk);

    // ramp
    run_frame(-1, -1, 1600);
    check_frame("ramp");
    check_ramp("ramp");

    // start pulses while busy and during done
    run_frame(10, 1570, 1600);
    check_frame("start_busy");
    check_ramp("start_busy");

    // reset in the middle of a frame
    start = 1'b1;
    @(negedge iclk);
    start = 1'b0;
    repeat (100) @(negedge iclk);
    #2 irst = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    run_frame(-1, -1, 1600);
    check_frame("after_reset");
    check_ramp("after_reset");

    // back-to-back: second start lands in the first IDLE cycle after done
    run_frame(-1, -1, 1571);
    check_frame("b2b_first");
    check_ramp("b2b_first");
    run_frame(-1, -1, 1600);
    check_frame("b2b_second");
    check_ramp("b2b_second");

    // position sweep: 100 at sub-index idx%4, -5 elsewhere
    for (int idx = 0; idx < 392; idx++)
      for (int s = 0; s < 4; s++)
        mem[cell_addr(idx, s)] = (s == idx % 4) ? 16'd100 : 16'hFFFB;
    run_frame(-1, -1, 1600);
    check_frame("sweep");
    chk("sweep s0", f_out[0], 100);
    chk("sweep s1", f_out[1], 100);
    chk("sweep s2", f_out[2], 100);
    chk("sweep s3", f_out[3], 100);

    // most negative value everywhere
    for (int a = 0; a < 2048; a++) mem[a] = 16'h8000;
    run_frame(-1, -1, 1600);
    check_frame("extreme");
`ifdef POOL_RELU_EN
    chk("extreme pool0", f_out[0], 0);
    chk("extreme pool391", f_out[391], 0);
`else
    chk("extreme pool0", f_out[0], -32768);
    chk("extreme pool391", f_out[391], -32768);
`endif

    // ties
    for (int a = 0; a < 2048; a++) mem[a] = 16'd7;
    run_frame(-1, -1, 1600);
    check_frame("ties");
    chk("ties pool200", f_out[200], 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
